// File: rtl/tc_bus_pkg.sv
// Shared types for the 68000 bus-cycle controller: FSM state encoding,
// VRAM owner codes and the wait-counter width.
package tc_bus_pkg;

  localparam int CNT_W = 8;

  localparam logic OWN_CPU = 1'b0;
  localparam logic OWN_VID = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ROM,
    ST_RAM,
    ST_VRAM_REQ,
    ST_VRAM_HOLD,
    ST_IO,
    ST_ACK
  } bus_state_e;

  // Wait counter increments but sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

endpackage

// File: rtl/vram_rr_arbiter.sv
// Two-requester round-robin arbiter for the shared BG/FG video RAM port.
// Grants are combinational; only the last-owner flag is stored.
module vram_rr_arbiter
  import tc_bus_pkg::*;
(
  input  logic clk_sys,
  input  logic reset_n,
  input  logic cpu_req_i,
  input  logic vid_req_i,
  input  logic hold_i,
  output logic cpu_gnt_o,
  output logic vid_gnt_o
);

  logic rr_last_q, rr_last_d;

  // NOTE: every output of a combinational block gets a default first so no path can infer a latch.
  always_comb begin
    cpu_gnt_o = 1'b0;
    vid_gnt_o = 1'b0;
    if (!hold_i) begin
      if (cpu_req_i && vid_req_i) begin
        if (rr_last_q == OWN_CPU) vid_gnt_o = 1'b1;
        else                      cpu_gnt_o = 1'b1;
      end else begin
        cpu_gnt_o = cpu_req_i;
        vid_gnt_o = vid_req_i;
      end
    end

    rr_last_d = rr_last_q;
    if (cpu_gnt_o)      rr_last_d = OWN_CPU;
    else if (vid_gnt_o) rr_last_d = OWN_VID;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_sys) begin
    if (!reset_n) rr_last_q <= OWN_CPU;
    else          rr_last_q <= rr_last_d;
  end

endmodule

// File: rtl/m68k_bus_ctrl.sv
// 68000 bus-cycle sequencer: per-region wait states, SDRAM ROM handshake,
// DTACK generation and CPU side of the shared VRAM port.
module m68k_bus_ctrl
  import tc_bus_pkg::*;
#(
  parameter int unsigned RAM_WAIT    = 1,
  parameter int unsigned VRAM_WAIT   = 1,
  parameter int unsigned IO_WAIT     = 0,
  parameter int unsigned ROM_TIMEOUT = 255
) (
  input  logic clk_sys,
  input  logic reset_n,
  input  logic m68k_as_n,
  input  logic prog_rom_cs,
  input  logic ram_cs,
  input  logic vram_cs,
  input  logic io_cs,
  input  logic rom_ack,
  input  logic vid_req,
  output logic rom_req,
  output logic m68k_dtack_n,
  output logic vram_owner,
  output logic vid_gnt,
  output logic rom_timeout,
  output logic open_bus
);

  localparam logic [CNT_W-1:0] RAM_WAIT_C    = CNT_W'(RAM_WAIT);
  localparam logic [CNT_W-1:0] VRAM_WAIT_C   = CNT_W'(VRAM_WAIT);
  localparam logic [CNT_W-1:0] IO_WAIT_C     = CNT_W'(IO_WAIT);
  localparam logic [CNT_W-1:0] ROM_TIMEOUT_C = CNT_W'(ROM_TIMEOUT);

  bus_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             as_q, as_prev_q;
  logic             dtack_n_q, dtack_n_d;
  logic             rom_req_q, rom_req_d;
  logic             vram_owner_q, vram_owner_d;
  logic             vid_gnt_q, vid_gnt_d;
  logic             rom_timeout_q, rom_timeout_d;
  logic             open_bus_q, open_bus_d;

  logic cycle_start, hold_done;
  logic arb_cpu_gnt, arb_vid_gnt;

  assign cycle_start = as_prev_q & ~as_q;
  assign hold_done   = (cnt_q >= VRAM_WAIT_C);

  // The port is released on the last hold edge so a waiting fetcher gets the very next slot.
  vram_rr_arbiter u_arb (
    .clk_sys   (clk_sys),
    .reset_n   (reset_n),
    .cpu_req_i (state_q == ST_VRAM_REQ && !as_q),
    .vid_req_i (vid_req),
    .hold_i    (state_q == ST_VRAM_HOLD && !hold_done),
    .cpu_gnt_o (arb_cpu_gnt),
    .vid_gnt_o (arb_vid_gnt)
  );

  always_comb begin
    state_d       = state_q;
    rom_timeout_d = rom_timeout_q;
    open_bus_d    = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (cycle_start) begin
          if (prog_rom_cs)  state_d = ST_ROM;
          else if (ram_cs)  state_d = ST_RAM;
          else if (vram_cs) state_d = ST_VRAM_REQ;
          else begin
            state_d    = ST_IO;
            open_bus_d = !io_cs;
          end
        end
      end
      ST_ROM: begin
        if (as_q)                         state_d = ST_IDLE;
        else if (rom_ack)                 state_d = ST_ACK;
        else if (cnt_q == ROM_TIMEOUT_C) begin
          state_d       = ST_ACK;
          rom_timeout_d = 1'b1;
        end
      end
      ST_RAM: begin
        if (as_q)                     state_d = ST_IDLE;
        else if (cnt_q >= RAM_WAIT_C) state_d = ST_ACK;
      end
      ST_IO: begin
        if (as_q)                    state_d = ST_IDLE;
        else if (cnt_q >= IO_WAIT_C) state_d = ST_ACK;
      end
      ST_VRAM_REQ: begin
        if (as_q)             state_d = ST_IDLE;
        else if (arb_cpu_gnt) state_d = ST_VRAM_HOLD;
      end
      ST_VRAM_HOLD: begin
        if (as_q)           state_d = ST_IDLE;
        else if (hold_done) state_d = ST_ACK;
      end
      ST_ACK: begin
        if (as_q) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    cnt_d        = (state_d != state_q) ? '0 : sat_inc(cnt_q);
    rom_req_d    = (state_d == ST_ROM);
    dtack_n_d    = (state_d != ST_ACK);
    vid_gnt_d    = arb_vid_gnt;
    vram_owner_d = arb_vid_gnt ? OWN_VID : OWN_CPU;
  end

  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      as_q          <= 1'b1;
      as_prev_q     <= 1'b1;
      dtack_n_q     <= 1'b1;
      rom_req_q     <= 1'b0;
      vram_owner_q  <= OWN_CPU;
      vid_gnt_q     <= 1'b0;
      rom_timeout_q <= 1'b0;
      open_bus_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      as_q          <= m68k_as_n;
      as_prev_q     <= as_q;
      dtack_n_q     <= dtack_n_d;
      rom_req_q     <= rom_req_d;
      vram_owner_q  <= vram_owner_d;
      vid_gnt_q     <= vid_gnt_d;
      rom_timeout_q <= rom_timeout_d;
      open_bus_q    <= open_bus_d;
    end
  end

  assign rom_req      = rom_req_q;
  assign m68k_dtack_n = dtack_n_q;
  assign vram_owner   = vram_owner_q;
  assign vid_gnt      = vid_gnt_q;
  assign rom_timeout  = rom_timeout_q;
  assign open_bus     = open_bus_q;

endmodule

// File: tb/tb_m68k_bus_ctrl.sv
// Directed bench for m68k_bus_ctrl. T0 is the clock edge where AS is first
// sampled low; "kN" tags name the sample taken just after edge T0+N.
module tb_m68k_bus_ctrl;

  logic clk_sys = 1'b0;
  logic reset_n, m68k_as_n, prog_rom_cs, ram_cs, vram_cs, io_cs, rom_ack, vid_req;
  logic rom_req, m68k_dtack_n, vram_owner, vid_gnt, rom_timeout, open_bus;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk_sys = ~clk_sys;

  m68k_bus_ctrl dut (
    .clk_sys      (clk_sys),
    .reset_n      (reset_n),
    .m68k_as_n    (m68k_as_n),
    .prog_rom_cs  (prog_rom_cs),
    .ram_cs       (ram_cs),
    .vram_cs      (vram_cs),
    .io_cs        (io_cs),
    .rom_ack      (rom_ack),
    .vid_req      (vid_req),
    .rom_req      (rom_req),
    .m68k_dtack_n (m68k_dtack_n),
    .vram_owner   (vram_owner),
    .vid_gnt      (vid_gnt),
    .rom_timeout  (rom_timeout),
    .open_bus     (open_bus)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk_sys);
  endtask

  // Drive AS low with the given select, then advance to sample k0.
  task automatic begin_cycle(input logic rom, input logic ram, input logic vram, input logic io);
    m68k_as_n   = 1'b0;
    prog_rom_cs = rom;
    ram_cs      = ram;
    vram_cs     = vram;
    io_cs       = io;
    step(1);
  endtask

  task automatic end_cycle();
    m68k_as_n   = 1'b1;
    prog_rom_cs = 1'b0;
    ram_cs      = 1'b0;
    vram_cs     = 1'b0;
    io_cs       = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    reset_n = 1'b0;
    rom_ack = 1'b0;
    vid_req = 1'b0;
    end_cycle();
    step(2);
    check("rst_dtack_n", m68k_dtack_n, 1);
    check("rst_rom_req", rom_req, 0);
    check("rst_vram_owner", vram_owner, 0);
    check("rst_vid_gnt", vid_gnt, 0);
    check("rst_rom_timeout", rom_timeout, 0);
    check("rst_open_bus", open_bus, 0);
    reset_n = 1'b1;
    step(2);

    // Work RAM read, one wait state.
    begin_cycle(0, 1, 0, 0);
    check("ram_k0_dtack", m68k_dtack_n, 1);
    step(2);
    check("ram_k2_dtack", m68k_dtack_n, 1);
    step(1);
    check("ram_k3_dtack", m68k_dtack_n, 0);
    end_cycle();
    step(1);
    check("ram_k4_dtack_held", m68k_dtack_n, 0);
    step(1);
    check("ram_k5_dtack_release", m68k_dtack_n, 1);
    step(2);

    // Program ROM read, ack sampled at T0+6.
    begin_cycle(1, 0, 0, 0);
    check("rom_k0_req", rom_req, 0);
    step(1);
    check("rom_k1_req", rom_req, 1);
    step(4);
    check("rom_k5_req", rom_req, 1);
    check("rom_k5_dtack", m68k_dtack_n, 1);
    rom_ack = 1'b1;
    step(1);
    rom_ack = 1'b0;
    check("rom_k6_req", rom_req, 0);
    check("rom_k6_dtack", m68k_dtack_n, 0);
    check("rom_k6_timeout", rom_timeout, 0);
    end_cycle();
    step(3);
    check("rom_end_dtack", m68k_dtack_n, 1);

    // ROM read with no ack: forced DTACK after the timeout.
    begin_cycle(1, 0, 0, 0);
    k = 0;
    while (m68k_dtack_n === 1'b1 && k < 400) begin
      step(1);
      k++;
    end
    check("rom_to_latency", k, 257);
    check("rom_to_req_drop", rom_req, 0);
    check("rom_to_sticky", rom_timeout, 1);
    end_cycle();
    step(3);
    check("rom_to_still_sticky", rom_timeout, 1);
    reset_n = 1'b0;
    step(1);
    reset_n = 1'b1;
    step(1);
    check("rom_to_cleared", rom_timeout, 0);
    step(1);

    // Unmapped access.
    begin_cycle(0, 0, 0, 0);
    check("unm_k0_open_bus", open_bus, 0);
    step(1);
    check("unm_k1_open_bus", open_bus, 1);
    check("unm_k1_dtack", m68k_dtack_n, 1);
    step(1);
    check("unm_k2_open_bus", open_bus, 0);
    check("unm_k2_dtack", m68k_dtack_n, 0);
    end_cycle();
    step(3);

    // AS abort during ROM wait, then a normal RAM cycle.
    begin_cycle(1, 0, 0, 0);
    step(3);
    check("abt_k3_req", rom_req, 1);
    end_cycle();
    step(1);
    check("abt_k4_req", rom_req, 1);
    step(1);
    check("abt_k5_req", rom_req, 0);
    check("abt_k5_dtack", m68k_dtack_n, 1);
    step(1);
    check("abt_k6_dtack", m68k_dtack_n, 1);
    begin_cycle(0, 1, 0, 0);
    step(3);
    check("abt_ram_k3_dtack", m68k_dtack_n, 0);
    end_cycle();
    step(3);

    // Continuous fetcher requests, no CPU traffic.
    vid_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step(1);
      check("vid_cont_gnt", vid_gnt, 1);
      check("vid_cont_owner", vram_owner, 1);
    end

    // CPU VRAM cycle with video last owner: CPU first, video after hold.
    begin_cycle(0, 0, 1, 0);
    check("cpu1_k0_vgnt", vid_gnt, 1);
    step(1);
    check("cpu1_k1_vgnt", vid_gnt, 1);
    step(1);
    check("cpu1_k2_vgnt", vid_gnt, 0);
    check("cpu1_k2_owner", vram_owner, 0);
    step(1);
    check("cpu1_k3_vgnt", vid_gnt, 0);
    check("cpu1_k3_owner", vram_owner, 0);
    check("cpu1_k3_dtack", m68k_dtack_n, 1);
    step(1);
    check("cpu1_k4_vgnt", vid_gnt, 1);
    check("cpu1_k4_owner", vram_owner, 1);
    check("cpu1_k4_dtack", m68k_dtack_n, 0);
    vid_req = 1'b0;
    end_cycle();
    step(1);
    check("cpu1_k5_vgnt", vid_gnt, 0);
    step(2);

    // Reset asserted during VRAM hold.
    begin_cycle(0, 0, 1, 0);
    step(2);
    check("rsth_k2_owner", vram_owner, 0);
    check("rsth_k2_dtack", m68k_dtack_n, 1);
    reset_n = 1'b0;
    end_cycle();
    step(1);
    check("rsth_dtack", m68k_dtack_n, 1);
    check("rsth_owner", vram_owner, 0);
    check("rsth_rom_req", rom_req, 0);
    check("rsth_vgnt", vid_gnt, 0);
    reset_n = 1'b1;
    step(2);

    // CPU last owner after reset: contending video request wins first.
    begin_cycle(0, 0, 1, 0);
    step(1);
    vid_req = 1'b1;
    step(1);
    check("vid1_k2_vgnt", vid_gnt, 1);
    check("vid1_k2_owner", vram_owner, 1);
    vid_req = 1'b0;
    step(1);
    check("vid1_k3_vgnt", vid_gnt, 0);
    check("vid1_k3_owner", vram_owner, 0);
    check("vid1_k3_dtack", m68k_dtack_n, 1);
    step(1);
    check("vid1_k4_dtack", m68k_dtack_n, 1);
    step(1);
    check("vid1_k5_dtack", m68k_dtack_n, 0);
    end_cycle();
    step(1);
    check("vid1_k6_dtack", m68k_dtack_n, 0);
    step(1);
    check("vid1_k7_dtack", m68k_dtack_n, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
